// File: rtl/traffic_pkg.sv
// Shared definitions for the four-way junction light bus.
// Holds the light code constants, the monitor phase encodings, the default
// dwell times shared with the light controller, and small decode helpers.
package traffic_pkg;

    // Light code width and one-hot light codes driven on each approach.
    localparam int unsigned LT_W      = 3;
    localparam logic [2:0]  LT_GREEN  = 3'b001;
    localparam logic [2:0]  LT_YELLOW = 3'b010;
    localparam logic [2:0]  LT_RED    = 3'b100;

    // Monitor phase encodings. PH_SYNC doubles as "no recognisable phase".
    localparam int unsigned PH_W    = 3;
    localparam logic [2:0]  PH_SYNC = 3'd0;
    localparam logic [2:0]  PH_NS_G = 3'd1;
    localparam logic [2:0]  PH_NS_Y = 3'd2;
    localparam logic [2:0]  PH_EW_G = 3'd3;
    localparam logic [2:0]  PH_EW_Y = 3'd4;

    // Defaults shared with the controller so both sides agree on dwell.
    localparam int unsigned DEF_GREEN_CYC      = 8;
    localparam int unsigned DEF_YELLOW_CYC     = 4;
    localparam int unsigned DEF_PAIRS_PER_AXIS = 2;
    localparam int unsigned DEF_CNT_W          = 5;

    // Rotation counter width.
    localparam int unsigned ROT_W = 16;

    // Per-cycle error set requests, one bit per sticky flag.
    typedef struct packed {
        logic encode;
        logic pair;
        logic conflict;
        logic seq;
        logic timing;
    } err_set_t;

    // True when a code is one of the three legal light codes.
    function automatic logic code_legal(input logic [2:0] code);
        return (code == LT_GREEN) || (code == LT_YELLOW) || (code == LT_RED);
    endfunction

    // Map an (NS, EW) light pair to the phase it represents; PH_SYNC if none.
    function automatic logic [2:0] classify(input logic [2:0] ns, input logic [2:0] ew);
        logic [2:0] ph;
        ph = PH_SYNC;
        if (ew == LT_RED) begin
            if (ns == LT_GREEN)       ph = PH_NS_G;
            else if (ns == LT_YELLOW) ph = PH_NS_Y;
        end else if (ns == LT_RED) begin
            if (ew == LT_GREEN)       ph = PH_EW_G;
            else if (ew == LT_YELLOW) ph = PH_EW_Y;
        end
        return ph;
    endfunction

endpackage

// File: rtl/sticky_flag.sv
// Sticky error flag: set holds the flag until clr; set dominates clr.
// Ports:
//   clk      system clock, rising edge
//   rst_a_n  asynchronous active-low reset (flag -> 0)
//   set      set request for this cycle
//   clr      synchronous clear request
//   flag     registered sticky flag
module sticky_flag (
    input  logic clk,
    input  logic rst_a_n,
    input  logic set,
    input  logic clr,
    output logic flag
);

    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            flag <= 1'b0;
        end else if (set) begin
            flag <= 1'b1;
        end else if (clr) begin
            flag <= 1'b0;
        end
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive monitor for the four-way junction light bus. Rebuilds the phase
// sequence from the observed light codes and raises sticky error flags for
// illegal codes, unpaired approaches, conflicting axes, illegal phase order
// and wrong dwell times. It never drives the lights.
// Ports:
//   clk, rst_a_n                   clock, asynchronous active-low reset
//   n/s/e/w_lights [2:0]           observed light codes
//   clr_err                        synchronous clear of all sticky flags
//   err_encode/pair/conflict/seq/timing   sticky error flags
//   err_any                        OR of the five sticky flags
//   synced                         monitor locked to the light sequence
//   phase [2:0]                    tracked phase (SYNC/NS_G/NS_Y/EW_G/EW_Y)
//   dwell [CNT_W-1:0]              cycles in the current phase, saturating
//   rotations [15:0]               completed NS+EW cycles, wrapping
module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter int unsigned GREEN_CYC      = DEF_GREEN_CYC,
    parameter int unsigned YELLOW_CYC     = DEF_YELLOW_CYC,
    parameter int unsigned PAIRS_PER_AXIS = DEF_PAIRS_PER_AXIS,
    parameter int unsigned CNT_W          = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_a_n,
    input  logic [LT_W-1:0]   n_lights,
    input  logic [LT_W-1:0]   s_lights,
    input  logic [LT_W-1:0]   e_lights,
    input  logic [LT_W-1:0]   w_lights,
    input  logic              clr_err,
    output logic              err_encode,
    output logic              err_pair,
    output logic              err_conflict,
    output logic              err_seq,
    output logic              err_timing,
    output logic              err_any,
    output logic              synced,
    output logic [PH_W-1:0]   phase,
    output logic [CNT_W-1:0]  dwell,
    output logic [ROT_W-1:0]  rotations
);

    localparam int unsigned    PCNT_W     = $clog2(PAIRS_PER_AXIS + 1);
    localparam logic [CNT_W-1:0]  DWELL_MAX  = '1;
    localparam logic [CNT_W-1:0]  DWELL_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  GREEN_REQ  = CNT_W'(GREEN_CYC);
    localparam logic [CNT_W-1:0]  YELLOW_REQ = CNT_W'(YELLOW_CYC);
    localparam logic [PCNT_W-1:0] PAIRS_REQ  = PCNT_W'(PAIRS_PER_AXIS);
    localparam logic [PCNT_W-1:0] PCNT_ONE   = PCNT_W'(1);

    // Tracking state (phase, dwell, rotations, synced are the outputs).
    logic [PCNT_W-1:0] pcnt_q;
    logic              partial_q;

    // Next-state values.
    logic [PH_W-1:0]   phase_nxt;
    logic [CNT_W-1:0]  dwell_nxt;
    logic [PCNT_W-1:0] pcnt_nxt;
    logic              partial_nxt;
    logic [ROT_W-1:0]  rot_nxt;
    logic              synced_nxt;

    // Per-cycle decode of the sampled bus.
    logic              enc_bad_c;
    logic              pair_bad_c;
    logic              conf_bad_c;
    logic              clean_c;
    logic [PH_W-1:0]   obs_c;
    logic              is_green_c;
    logic [CNT_W-1:0]  req_c;
    logic              legal_c;
    logic [PCNT_W-1:0] pcnt_leg_c;
    logic              rot_inc_c;
    err_set_t          err_set;
    logic              any_set_c;

    // Always-on bus checks and phase classification of the current sample.
    always_comb begin
        enc_bad_c  = !(code_legal(n_lights) && code_legal(s_lights) &&
                       code_legal(e_lights) && code_legal(w_lights));
        pair_bad_c = (n_lights != s_lights) || (e_lights != w_lights);
        conf_bad_c = (n_lights != LT_RED) && (e_lights != LT_RED);
        clean_c    = !(enc_bad_c || pair_bad_c || conf_bad_c);
        obs_c      = classify(n_lights, e_lights);
        is_green_c = (phase == PH_NS_G) || (phase == PH_EW_G);
        req_c      = is_green_c ? GREEN_REQ : YELLOW_REQ;
    end

    // Legal successor of the tracked phase and the pair/rotation side effects.
    always_comb begin
        legal_c    = 1'b0;
        pcnt_leg_c = pcnt_q;
        rot_inc_c  = 1'b0;
        case (phase)
            PH_NS_G: legal_c = (obs_c == PH_NS_Y);
            PH_EW_G: legal_c = (obs_c == PH_EW_Y);
            PH_NS_Y: begin
                if ((obs_c == PH_NS_G) && (pcnt_q < PAIRS_REQ)) begin
                    legal_c    = 1'b1;
                    pcnt_leg_c = pcnt_q + PCNT_ONE;
                end else if ((obs_c == PH_EW_G) && (pcnt_q == PAIRS_REQ)) begin
                    legal_c    = 1'b1;
                    pcnt_leg_c = PCNT_ONE;
                end
            end
            PH_EW_Y: begin
                if ((obs_c == PH_EW_G) && (pcnt_q < PAIRS_REQ)) begin
                    legal_c    = 1'b1;
                    pcnt_leg_c = pcnt_q + PCNT_ONE;
                end else if ((obs_c == PH_NS_G) && (pcnt_q == PAIRS_REQ)) begin
                    legal_c    = 1'b1;
                    pcnt_leg_c = PCNT_ONE;
                    rot_inc_c  = 1'b1;
                end
            end
            default: legal_c = 1'b0;
        endcase
    end

    // Phase tracker next-state and error set requests.
    always_comb begin
        phase_nxt       = phase;
        dwell_nxt       = dwell;
        pcnt_nxt        = pcnt_q;
        partial_nxt     = partial_q;
        rot_nxt         = rotations;
        synced_nxt      = synced;
        err_set         = '0;
        err_set.encode   = enc_bad_c;
        err_set.pair     = pair_bad_c;
        err_set.conflict = conf_bad_c;

        if (phase == PH_SYNC) begin
            // Lock only onto a clean green so the pair count starts aligned.
            if (clean_c && ((obs_c == PH_NS_G) || (obs_c == PH_EW_G))) begin
                phase_nxt   = obs_c;
                dwell_nxt   = DWELL_ONE;
                pcnt_nxt    = PCNT_ONE;
                partial_nxt = 1'b1;
                synced_nxt  = 1'b1;
            end
        end else if (!clean_c) begin
            phase_nxt   = PH_SYNC;
            dwell_nxt   = '0;
            pcnt_nxt    = '0;
            partial_nxt = 1'b0;
            synced_nxt  = 1'b0;
        end else if (obs_c == phase) begin
            // Overstay fires once: dwell passes req exactly once per phase.
            if (dwell == req_c) err_set.timing = 1'b1;
            if (dwell != DWELL_MAX) dwell_nxt = dwell + DWELL_ONE;
        end else if (legal_c) begin
            // The phase seen at lock-in is partial, so skip its understay.
            if (!partial_q && (dwell < req_c)) err_set.timing = 1'b1;
            phase_nxt   = obs_c;
            dwell_nxt   = DWELL_ONE;
            pcnt_nxt    = pcnt_leg_c;
            partial_nxt = 1'b0;
            if (rot_inc_c) rot_nxt = rotations + ROT_W'(1);
        end else begin
            err_set.seq = 1'b1;
            phase_nxt   = PH_SYNC;
            dwell_nxt   = '0;
            pcnt_nxt    = '0;
            partial_nxt = 1'b0;
            synced_nxt  = 1'b0;
        end
    end

    // Tracker state register.
    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            phase     <= PH_SYNC;
            dwell     <= '0;
            pcnt_q    <= '0;
            partial_q <= 1'b0;
            rotations <= '0;
            synced    <= 1'b0;
        end else begin
            phase     <= phase_nxt;
            dwell     <= dwell_nxt;
            pcnt_q    <= pcnt_nxt;
            partial_q <= partial_nxt;
            rotations <= rot_nxt;
            synced    <= synced_nxt;
        end
    end

    // Sticky error flags.
    sticky_flag u_err_encode (
        .clk     (clk),
        .rst_a_n (rst_a_n),
        .set     (err_set.encode),
        .clr     (clr_err),
        .flag    (err_encode)
    );

    sticky_flag u_err_pair (
        .clk     (clk),
        .rst_a_n (rst_a_n),
        .set     (err_set.pair),
        .clr     (clr_err),
        .flag    (err_pair)
    );

    sticky_flag u_err_conflict (
        .clk     (clk),
        .rst_a_n (rst_a_n),
        .set     (err_set.conflict),
        .clr     (clr_err),
        .flag    (err_conflict)
    );

    sticky_flag u_err_seq (
        .clk     (clk),
        .rst_a_n (rst_a_n),
        .set     (err_set.seq),
        .clr     (clr_err),
        .flag    (err_seq)
    );

    sticky_flag u_err_timing (
        .clk     (clk),
        .rst_a_n (rst_a_n),
        .set     (err_set.timing),
        .clr     (clr_err),
        .flag    (err_timing)
    );

    // Registered summary flag; tracks the OR of the five flags because all
    // share the same clear and set-dominant priority.
    assign any_set_c = err_set.encode | err_set.pair | err_set.conflict |
                       err_set.seq | err_set.timing;

    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            err_any <= 1'b0;
        end else begin
            err_any <= any_set_c | (err_any & ~clr_err);
        end
    end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Self-checking bench for traffic_light_monitor: directed scenarios followed
// by randomized light sequences with injected faults, every cycle compared
// against a behavioural model of the monitor rules.
module tb_traffic_light_monitor;

    localparam int unsigned G_CYC = 8;
    localparam int unsigned Y_CYC = 4;
    localparam int unsigned PAIRS = 2;
    localparam int unsigned CW    = 5;
    localparam int          DWELL_MAX = 31;

    localparam logic [2:0] C_G = 3'b001;
    localparam logic [2:0] C_Y = 3'b010;
    localparam logic [2:0] C_R = 3'b100;

    logic        clk = 1'b0;
    logic        rst_a_n;
    logic [2:0]  n_lights, s_lights, e_lights, w_lights;
    logic        clr_err;
    logic        err_encode, err_pair, err_conflict, err_seq, err_timing, err_any;
    logic        synced;
    logic [2:0]  phase;
    logic [CW-1:0] dwell;
    logic [15:0] rotations;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: lock, active axis (0 NS / 1 EW), colour, run length.
    bit       m_locked;
    int       m_axis;
    bit       m_yel;
    int       m_run;
    int       m_pairs;
    bit       m_partial;
    int       m_rot;
    bit [4:0] m_err;   // encode, pair, conflict, seq, timing

    traffic_light_monitor #(
        .GREEN_CYC      (G_CYC),
        .YELLOW_CYC     (Y_CYC),
        .PAIRS_PER_AXIS (PAIRS),
        .CNT_W          (CW)
    ) dut (
        .clk          (clk),
        .rst_a_n      (rst_a_n),
        .n_lights     (n_lights),
        .s_lights     (s_lights),
        .e_lights     (e_lights),
        .w_lights     (w_lights),
        .clr_err      (clr_err),
        .err_encode   (err_encode),
        .err_pair     (err_pair),
        .err_conflict (err_conflict),
        .err_seq      (err_seq),
        .err_timing   (err_timing),
        .err_any      (err_any),
        .synced       (synced),
        .phase        (phase),
        .dwell        (dwell),
        .rotations    (rotations)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit legal_code(input logic [2:0] c);
        return (c == C_G) || (c == C_Y) || (c == C_R);
    endfunction

    task automatic model_reset();
        m_locked = 0; m_axis = 0; m_yel = 0; m_run = 0;
        m_pairs = 0; m_partial = 0; m_rot = 0; m_err = '0;
    endtask

    // One clock of the monitor rules applied to the sampled bus.
    task automatic model_step(input logic [2:0] n, input logic [2:0] s,
                              input logic [2:0] e, input logic [2:0] w, input logic clr);
        bit se, sp, sc, sq, st, clean, active, o_yel, nx_yel;
        int o_axis, nx_axis, req;
        bit [4:0] sets;
        se = !(legal_code(n) && legal_code(s) && legal_code(e) && legal_code(w));
        sp = (n != s) || (e != w);
        sc = (n != C_R) && (e != C_R);
        sq = 0;
        st = 0;
        clean  = !(se || sp || sc);
        active = (n != C_R) || (e != C_R);
        o_axis = (n != C_R) ? 0 : 1;
        o_yel  = (((o_axis == 0) ? n : e) == C_Y);
        req    = m_yel ? int'(Y_CYC) : int'(G_CYC);
        if (!m_locked) begin
            if (clean && active && !o_yel) begin
                m_locked = 1; m_axis = o_axis; m_yel = 0;
                m_run = 1; m_pairs = 1; m_partial = 1;
            end
        end else if (!clean) begin
            m_locked = 0;
        end else if (active && o_axis == m_axis && o_yel == m_yel) begin
            if (m_run + 1 > req && m_run <= req) st = 1;
            if (m_run < DWELL_MAX) m_run++;
        end else begin
            if (!m_yel) begin
                nx_axis = m_axis; nx_yel = 1;
            end else if (m_pairs < int'(PAIRS)) begin
                nx_axis = m_axis; nx_yel = 0;
            end else begin
                nx_axis = 1 - m_axis; nx_yel = 0;
            end
            if (active && o_axis == nx_axis && o_yel == nx_yel) begin
                if (!m_partial && m_run < req) st = 1;
                if (m_yel) m_pairs = (nx_axis == m_axis) ? m_pairs + 1 : 1;
                if (m_yel && m_axis == 1 && nx_axis == 0) m_rot = (m_rot + 1) % 65536;
                m_axis = nx_axis; m_yel = nx_yel; m_run = 1; m_partial = 0;
            end else begin
                sq = 1;
                m_locked = 0;
            end
        end
        sets = {st, sq, sc, sp, se};
        for (int i = 0; i < 5; i++)
            m_err[i] = sets[i] | (m_err[i] & !clr);
    endtask

    task automatic compare_all();
        check_eq("err_encode",   32'(err_encode),   32'(m_err[0]));
        check_eq("err_pair",     32'(err_pair),     32'(m_err[1]));
        check_eq("err_conflict", 32'(err_conflict), 32'(m_err[2]));
        check_eq("err_seq",      32'(err_seq),      32'(m_err[3]));
        check_eq("err_timing",   32'(err_timing),   32'(m_err[4]));
        check_eq("err_any",      32'(err_any),      32'(|m_err));
        check_eq("synced",       32'(synced),       32'(m_locked));
        check_eq("phase",        32'(phase),        32'(m_locked ? 1 + 2 * m_axis + int'(m_yel) : 0));
        check_eq("dwell",        32'(dwell),        32'(m_locked ? m_run : 0));
        check_eq("rotations",    32'(rotations),    32'(m_rot));
    endtask

    // Drive one sample while clk is low, model the edge, check at negedge.
    task automatic step(input logic [2:0] n, input logic [2:0] s,
                        input logic [2:0] e, input logic [2:0] w, input logic clr);
        n_lights = n; s_lights = s; e_lights = e; w_lights = w; clr_err = clr;
        @(posedge clk);
        model_step(n, s, e, w, clr);
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive_phase(input int axis, input bit yel, input int cycles);
        logic [2:0] a;
        a = yel ? C_Y : C_G;
        for (int i = 0; i < cycles; i++) begin
            if (axis == 0) step(a, a, C_R, C_R, 1'b0);
            else           step(C_R, C_R, a, a, 1'b0);
        end
    endtask

    // Reset between clock edges; outputs must clear before any edge.
    task automatic async_reset();
        #2;
        rst_a_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst_a_n = 1'b1;
    endtask

    initial begin
        int g_axis, g_pairs, g_left, base, r;
        bit g_yel;
        logic [2:0] n, s, e, w;

        rst_a_n = 1'b0;
        n_lights = C_R; s_lights = C_R; e_lights = C_R; w_lights = C_R;
        clr_err = 1'b0;
        model_reset();
        #20;
        compare_all();
        @(negedge clk);
        rst_a_n = 1'b1;

        // Legal sequence, three rotations of the schedule.
        for (int rep = 0; rep < 3; rep++) begin
            drive_phase(0, 0, G_CYC); drive_phase(0, 1, Y_CYC);
            drive_phase(0, 0, G_CYC); drive_phase(0, 1, Y_CYC);
            drive_phase(1, 0, G_CYC); drive_phase(1, 1, Y_CYC);
            drive_phase(1, 0, G_CYC); drive_phase(1, 1, Y_CYC);
        end
        check_eq("legal_rotations", 32'(rotations), 32'd2);
        check_eq("legal_err_any",   32'(err_any),   32'd0);
        check_eq("legal_synced",    32'(synced),    32'd1);

        // Conflict, stickiness and clear.
        step(C_G, C_G, C_Y, C_Y, 1'b0);
        check_eq("conflict_flag",   32'(err_conflict), 32'd1);
        check_eq("conflict_any",    32'(err_any),      32'd1);
        check_eq("conflict_unsync", 32'(synced),       32'd0);
        drive_phase(0, 0, 3);
        check_eq("conflict_sticky", 32'(err_conflict), 32'd1);
        step(C_G, C_G, C_R, C_R, 1'b1);
        check_eq("conflict_clr",    32'(err_conflict), 32'd0);

        // Pair then encode.
        step(C_G, C_R, C_R, C_R, 1'b0);
        check_eq("pair_flag",       32'(err_pair),   32'd1);
        check_eq("pair_no_encode",  32'(err_encode), 32'd0);
        step(C_R, C_R, 3'b011, 3'b011, 1'b0);
        check_eq("encode_flag",     32'(err_encode), 32'd1);
        step(C_R, C_R, C_R, C_R, 1'b1);

        // Overstay on green, then understay on yellow without resync.
        drive_phase(0, 0, 9);
        check_eq("overstay",        32'(err_timing), 32'd1);
        step(C_Y, C_Y, C_R, C_R, 1'b1);
        check_eq("timing_clr",      32'(err_timing), 32'd0);
        drive_phase(0, 1, 1);
        drive_phase(0, 0, 1);
        check_eq("understay",       32'(err_timing), 32'd1);
        check_eq("understay_sync",  32'(synced),     32'd1);

        // Illegal jump NS green -> EW green, then relock.
        step(C_R, C_R, C_G, C_G, 1'b0);
        check_eq("seq_flag",        32'(err_seq), 32'd1);
        check_eq("seq_phase",       32'(phase),   32'd0);
        step(C_R, C_R, C_G, C_G, 1'b0);
        check_eq("seq_relock",      32'(phase),   32'd3);

        // Clear coincident with a new conflict: set wins.
        step(C_G, C_G, C_G, C_G, 1'b1);
        check_eq("clr_vs_set",      32'(err_conflict), 32'd1);
        check_eq("clr_other",       32'(err_seq),      32'd0);

        // Reset in the middle of EW yellow with flags set.
        drive_phase(0, 0, G_CYC); drive_phase(0, 1, Y_CYC);
        drive_phase(0, 0, G_CYC); drive_phase(0, 1, Y_CYC);
        drive_phase(1, 0, G_CYC); drive_phase(1, 1, 2);
        check_eq("pre_rst_phase",   32'(phase),   32'd4);
        check_eq("pre_rst_err",     32'(err_any), 32'd1);
        async_reset();
        check_eq("rst_err_any",     32'(err_any),   32'd0);
        check_eq("rst_rotations",   32'(rotations), 32'd0);
        check_eq("rst_phase",       32'(phase),     32'd0);

        // Randomized schedule with faults, dwell jitter and clears.
        g_axis = 0; g_yel = 0; g_pairs = 1; g_left = G_CYC;
        for (int it = 0; it < 1500; it++) begin
            if (g_axis == 0) begin
                n = g_yel ? C_Y : C_G; e = C_R;
            end else begin
                n = C_R; e = g_yel ? C_Y : C_G;
            end
            s = n; w = e;
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                n = C_G; s = C_G; e = C_Y; w = C_Y;
            end else if (r < 4) begin
                s = (n == C_Y) ? C_G : C_Y;
            end else if (r < 6) begin
                w = 3'($urandom_range(0, 7)); e = w;
            end else if (r < 7) begin
                n = C_R; s = C_R; e = C_R; w = C_R;
            end
            step(n, s, e, w, $urandom_range(0, 15) == 0);
            if (it == 900) async_reset();
            g_left--;
            if (g_left <= 0) begin
                if ($urandom_range(0, 39) == 0) begin
                    g_axis = int'($urandom_range(0, 1));
                    g_yel  = 1'($urandom_range(0, 1));
                end else if (!g_yel) begin
                    g_yel = 1;
                end else if (g_pairs < int'(PAIRS)) begin
                    g_yel = 0; g_pairs++;
                end else begin
                    g_yel = 0; g_axis = 1 - g_axis; g_pairs = 1;
                end
                base = g_yel ? int'(Y_CYC) : int'(G_CYC);
                r = int'($urandom_range(0, 9));
                if (r == 0)      g_left = (base > 2) ? base - 2 : 1;
                else if (r == 1) g_left = base + 2;
                else             g_left = base;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
